// File: rtl/udma_eth_tx_word_controller.sv
// ---------------------------------------------------------------------------
// udma_eth_tx_word_controller
//
// Fetches one Ethernet frame from L2 through the uDMA TX channel. The frame
// is split into a 32-bit word phase followed by a 0-3 byte remainder phase.
// Frames shorter than WORD_MIN_BYTES skip the word phase and use only the
// byte phase. Each phase is programmed into the uDMA channel with a one-cycle
// cfg_tx_en_o pulse. Fetched beats are forwarded to the MAC AXIS TX port.
// tuser flags the first beat of the frame. tlast flags the final beat across
// both phases.
//
// Ports
//   clk_i, rstn_i            clock, asynchronous active-low reset
//   cfg_tx_*_o               phase programming towards the uDMA core channel
//   cfg_tx_*_i               core channel status, passed back on reg_tx_*_o
//   reg_tx_*_i               frame request from the register file
//   busy_o, done_o           frame in progress / one-cycle completion pulse
//   data_tx_*                uDMA data fetch handshake
//   m_axis_*                 Ethernet MAC TX stream
// ---------------------------------------------------------------------------
module udma_eth_tx_word_controller #(
    parameter int L2_AWIDTH_NOAL = 12,
    parameter int TRANS_SIZE     = 16,
    parameter int WORD_MIN_BYTES = 8
) (
    input  logic                      clk_i,
    input  logic                      rstn_i,

    output logic [L2_AWIDTH_NOAL-1:0] cfg_tx_startaddr_o,
    output logic [TRANS_SIZE-1:0]     cfg_tx_size_o,
    output logic [1:0]                cfg_tx_datasize_o,
    output logic                      cfg_tx_continuous_o,
    output logic                      cfg_tx_en_o,
    output logic                      cfg_tx_clr_o,
    input  logic                      cfg_tx_en_i,
    input  logic                      cfg_tx_pending_i,
    input  logic [L2_AWIDTH_NOAL-1:0] cfg_tx_curr_addr_i,
    input  logic [TRANS_SIZE-1:0]     cfg_tx_bytes_left_i,

    input  logic [L2_AWIDTH_NOAL-1:0] reg_tx_startaddr_i,
    input  logic [TRANS_SIZE-1:0]     reg_tx_size_i,
    input  logic                      reg_tx_continuous_i,
    input  logic                      reg_tx_en_i,
    input  logic                      reg_tx_clr_i,
    output logic                      reg_tx_en_o,
    output logic                      reg_tx_pending_o,
    output logic [L2_AWIDTH_NOAL-1:0] reg_tx_curr_addr_o,
    output logic [TRANS_SIZE-1:0]     reg_tx_bytes_left_o,

    output logic                      busy_o,
    output logic                      done_o,

    output logic                      data_tx_req_o,
    input  logic                      data_tx_gnt_i,
    output logic [1:0]                data_tx_datasize_o,
    input  logic [31:0]               data_tx_i,
    input  logic                      data_tx_valid_i,
    output logic                      data_tx_ready_o,

    output logic [31:0]               m_axis_tdata_o,
    output logic [1:0]                m_axis_tsize_o,
    output logic                      m_axis_tvalid_o,
    output logic                      m_axis_tuser_o,
    output logic                      m_axis_tlast_o,
    input  logic                      m_axis_tready_i
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH_W,
        S_XFER_W,
        S_LAUNCH_B,
        S_XFER_B,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [L2_AWIDTH_NOAL-1:0] r_start;
    logic [TRANS_SIZE-3:0]     r_words;
    logic [TRANS_SIZE-1:0]     r_rem;      // wide enough for a short frame's full length
    logic [TRANS_SIZE-1:0]     r_beat_cnt; // beats accepted in the current phase
    logic                      r_tuser;
    logic                      r_done;
    logic                      r_cfg_en;
    logic [L2_AWIDTH_NOAL-1:0] r_cfg_addr;
    logic [TRANS_SIZE-1:0]     r_cfg_size;
    logic [1:0]                r_cfg_dsize;

    logic                      w_xfer;
    logic                      w_beat;
    logic                      w_start;
    logic                      w_short;
    logic [TRANS_SIZE-3:0]     w_words_in;
    logic [TRANS_SIZE-1:0]     w_rem_in;
    logic [TRANS_SIZE-1:0]     w_cnt_inc;
    logic                      w_phase_end;
    logic [TRANS_SIZE-1:0]     w_word_bytes;
    logic [L2_AWIDTH_NOAL-1:0] w_byte_addr;
    logic                      w_unused_gnt;

    // The data grant does not gate the stream; requests depend only on MAC ready.
    assign w_unused_gnt = data_tx_gnt_i;

    assign w_xfer  = (r_state == S_XFER_W) || (r_state == S_XFER_B);
    assign w_beat  = w_xfer && data_tx_valid_i && m_axis_tready_i;
    assign w_start = (r_state == S_IDLE) && reg_tx_en_i && !reg_tx_clr_i
                     && (reg_tx_size_i != '0);

    // Split of the requested length into whole words and trailing bytes.
    assign w_short    = reg_tx_size_i < TRANS_SIZE'(WORD_MIN_BYTES);
    assign w_words_in = w_short ? '0 : reg_tx_size_i[TRANS_SIZE-1:2];
    assign w_rem_in   = w_short ? reg_tx_size_i
                                : {{(TRANS_SIZE-2){1'b0}}, reg_tx_size_i[1:0]};

    assign w_cnt_inc   = r_beat_cnt + TRANS_SIZE'(1);
    assign w_phase_end = (r_state == S_XFER_W) ? (w_cnt_inc == {2'b00, r_words})
                                               : (w_cnt_inc == r_rem);

    // Byte phase starts right after the word phase; the address wraps in L2 space.
    assign w_word_bytes = {r_words, 2'b00};
    assign w_byte_addr  = r_start + L2_AWIDTH_NOAL'(w_word_bytes);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state <= S_IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of block order.
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        // NOTE: default first, so no path leaves w_state_nxt unassigned and
        // no latch is inferred.
        w_state_nxt = r_state;
        if (reg_tx_clr_i) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:     if (w_start) w_state_nxt = (w_words_in != '0) ? S_LAUNCH_W : S_LAUNCH_B;
                S_LAUNCH_W: w_state_nxt = S_XFER_W;
                S_XFER_W:   if (w_beat && w_phase_end) w_state_nxt = (r_rem == '0) ? S_DONE : S_LAUNCH_B;
                S_LAUNCH_B: w_state_nxt = S_XFER_B;
                S_XFER_B:   if (w_beat && w_phase_end) w_state_nxt = S_DONE;
                S_DONE:     w_state_nxt = S_IDLE;
                default:    w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            // NOTE: every register here is a control/config flop, so all get
            // a reset value; there is no storage array to leave unreset.
            r_start     <= '0;
            r_words     <= '0;
            r_rem       <= '0;
            r_beat_cnt  <= '0;
            r_tuser     <= 1'b0;
            r_done      <= 1'b0;
            r_cfg_en    <= 1'b0;
            r_cfg_addr  <= '0;
            r_cfg_size  <= '0;
            r_cfg_dsize <= 2'd0;
        end else begin
            r_cfg_en <= 1'b0;
            r_done   <= 1'b0;
            if (reg_tx_clr_i) begin
                r_beat_cnt <= '0;
                r_tuser    <= 1'b0;
            end else begin
                if (w_start) begin
                    r_start <= reg_tx_startaddr_i;
                    r_words <= w_words_in;
                    r_rem   <= w_rem_in;
                    r_tuser <= 1'b1;
                end
                if (w_beat) begin
                    r_tuser    <= 1'b0;
                    r_beat_cnt <= w_phase_end ? '0 : w_cnt_inc;
                end
                // Channel programming is registered on entry to a LAUNCH
                // state, so cfg_tx_en_o is high for exactly that cycle.
                if (r_state == S_IDLE && w_state_nxt == S_LAUNCH_W) begin
                    r_cfg_addr  <= reg_tx_startaddr_i;
                    r_cfg_size  <= {w_words_in, 2'b00};
                    r_cfg_dsize <= 2'd2;
                    r_cfg_en    <= 1'b1;
                end
                if (r_state != S_LAUNCH_B && w_state_nxt == S_LAUNCH_B) begin
                    r_cfg_addr  <= (r_state == S_IDLE) ? reg_tx_startaddr_i : w_byte_addr;
                    r_cfg_size  <= (r_state == S_IDLE) ? w_rem_in : r_rem;
                    r_cfg_dsize <= 2'd0;
                    r_cfg_en    <= 1'b1;
                end
                if (w_state_nxt == S_DONE) r_done <= 1'b1;
            end
        end
    end

    assign cfg_tx_startaddr_o  = r_cfg_addr;
    assign cfg_tx_size_o       = r_cfg_size;
    assign cfg_tx_datasize_o   = r_cfg_dsize;
    assign cfg_tx_continuous_o = reg_tx_continuous_i;
    assign cfg_tx_en_o         = r_cfg_en;
    assign cfg_tx_clr_o        = reg_tx_clr_i;

    assign reg_tx_en_o         = cfg_tx_en_i;
    assign reg_tx_pending_o    = cfg_tx_pending_i;
    assign reg_tx_curr_addr_o  = cfg_tx_curr_addr_i;
    assign reg_tx_bytes_left_o = cfg_tx_bytes_left_i;

    assign busy_o = (r_state != S_IDLE);
    assign done_o = r_done;

    assign data_tx_req_o      = w_xfer && m_axis_tready_i;
    assign data_tx_ready_o    = m_axis_tready_i;
    assign data_tx_datasize_o = r_cfg_dsize;

    assign m_axis_tdata_o  = data_tx_i;
    assign m_axis_tsize_o  = (r_state == S_XFER_W) ? 2'd3 : 2'd0;
    assign m_axis_tvalid_o = data_tx_valid_i && w_xfer;
    assign m_axis_tuser_o  = r_tuser;
    assign m_axis_tlast_o  = m_axis_tvalid_o && w_phase_end
                             && ((r_state == S_XFER_B) || (r_rem == '0));

endmodule

// File: tb/tb_udma_eth_tx_word_controller.sv
// ---------------------------------------------------------------------------
// Testbench for udma_eth_tx_word_controller. Expected channel launches and
// stream beats are queued when a frame is requested and popped when the DUT
// launches a phase or hands a beat to the MAC.
// ---------------------------------------------------------------------------
module tb_udma_eth_tx_word_controller;

    localparam int AW = 12;
    localparam int TS = 16;

    typedef struct {
        logic [AW-1:0] addr;
        logic [TS-1:0] size;
        logic [1:0]    dsize;
    } launch_t;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  tsize;
        logic        tuser;
        logic        tlast;
    } beat_t;

    logic          clk_i = 1'b0;
    logic          rstn_i;
    logic [AW-1:0] cfg_tx_startaddr_o;
    logic [TS-1:0] cfg_tx_size_o;
    logic [1:0]    cfg_tx_datasize_o;
    logic          cfg_tx_continuous_o;
    logic          cfg_tx_en_o;
    logic          cfg_tx_clr_o;
    logic          cfg_tx_en_i;
    logic          cfg_tx_pending_i;
    logic [AW-1:0] cfg_tx_curr_addr_i;
    logic [TS-1:0] cfg_tx_bytes_left_i;
    logic [AW-1:0] reg_tx_startaddr_i;
    logic [TS-1:0] reg_tx_size_i;
    logic          reg_tx_continuous_i;
    logic          reg_tx_en_i;
    logic          reg_tx_clr_i;
    logic          reg_tx_en_o;
    logic          reg_tx_pending_o;
    logic [AW-1:0] reg_tx_curr_addr_o;
    logic [TS-1:0] reg_tx_bytes_left_o;
    logic          busy_o;
    logic          done_o;
    logic          data_tx_req_o;
    logic          data_tx_gnt_i;
    logic [1:0]    data_tx_datasize_o;
    logic [31:0]   data_tx_i;
    logic          data_tx_valid_i;
    logic          data_tx_ready_o;
    logic [31:0]   m_axis_tdata_o;
    logic [1:0]    m_axis_tsize_o;
    logic          m_axis_tvalid_o;
    logic          m_axis_tuser_o;
    logic          m_axis_tlast_o;
    logic          m_axis_tready_i;

    udma_eth_tx_word_controller #(
        .L2_AWIDTH_NOAL(AW),
        .TRANS_SIZE    (TS),
        .WORD_MIN_BYTES(8)
    ) dut (
        .clk_i              (clk_i),
        .rstn_i             (rstn_i),
        .cfg_tx_startaddr_o (cfg_tx_startaddr_o),
        .cfg_tx_size_o      (cfg_tx_size_o),
        .cfg_tx_datasize_o  (cfg_tx_datasize_o),
        .cfg_tx_continuous_o(cfg_tx_continuous_o),
        .cfg_tx_en_o        (cfg_tx_en_o),
        .cfg_tx_clr_o       (cfg_tx_clr_o),
        .cfg_tx_en_i        (cfg_tx_en_i),
        .cfg_tx_pending_i   (cfg_tx_pending_i),
        .cfg_tx_curr_addr_i (cfg_tx_curr_addr_i),
        .cfg_tx_bytes_left_i(cfg_tx_bytes_left_i),
        .reg_tx_startaddr_i (reg_tx_startaddr_i),
        .reg_tx_size_i      (reg_tx_size_i),
        .reg_tx_continuous_i(reg_tx_continuous_i),
        .reg_tx_en_i        (reg_tx_en_i),
        .reg_tx_clr_i       (reg_tx_clr_i),
        .reg_tx_en_o        (reg_tx_en_o),
        .reg_tx_pending_o   (reg_tx_pending_o),
        .reg_tx_curr_addr_o (reg_tx_curr_addr_o),
        .reg_tx_bytes_left_o(reg_tx_bytes_left_o),
        .busy_o             (busy_o),
        .done_o             (done_o),
        .data_tx_req_o      (data_tx_req_o),
        .data_tx_gnt_i      (data_tx_gnt_i),
        .data_tx_datasize_o (data_tx_datasize_o),
        .data_tx_i          (data_tx_i),
        .data_tx_valid_i    (data_tx_valid_i),
        .data_tx_ready_o    (data_tx_ready_o),
        .m_axis_tdata_o     (m_axis_tdata_o),
        .m_axis_tsize_o     (m_axis_tsize_o),
        .m_axis_tvalid_o    (m_axis_tvalid_o),
        .m_axis_tuser_o     (m_axis_tuser_o),
        .m_axis_tlast_o     (m_axis_tlast_o),
        .m_axis_tready_i    (m_axis_tready_i)
    );

    always #5 clk_i = ~clk_i;

    int      n_cmp = 0;
    int      n_err = 0;
    int      n_beats = 0;
    int      done_cnt = 0;
    int      exp_idx = 0;   // next beat index the model expects
    int      src_idx = 0;   // next beat index the data source presents
    int      tr_mode = 0;   // 0: tready high, 1: toggle, 2: tready low
    launch_t launch_q[$];
    beat_t   beat_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] beat_data(input int i);
        return 32'(i) * 32'h9E37_79B9 + 32'h0000_1234;
    endfunction

    // Reference split and expected traffic for one frame; at most n_keep
    // beats are queued (a cleared frame stops early).
    task automatic push_frame(input logic [AW-1:0] start, input logic [TS-1:0] size,
                              input int n_keep);
        int      w, r;
        launch_t l;
        beat_t   b;
        if (size < 8) begin
            w = 0;
            r = int'(size);
        end else begin
            w = int'(size) / 4;
            r = int'(size) % 4;
        end
        if (w > 0) begin
            l.addr = start; l.size = TS'(w * 4); l.dsize = 2'd2;
            launch_q.push_back(l);
        end
        if (r > 0) begin
            l.addr = start + AW'(w * 4); l.size = TS'(r); l.dsize = 2'd0;
            launch_q.push_back(l);
        end
        for (int i = 0; i < w + r && i < n_keep; i++) begin
            b.data  = beat_data(exp_idx);
            b.tsize = (i < w) ? 2'd3 : 2'd0;
            b.tuser = (i == 0);
            b.tlast = (i == w + r - 1);
            beat_q.push_back(b);
            exp_idx++;
        end
    endtask

    task automatic request(input logic [AW-1:0] start, input logic [TS-1:0] size);
        reg_tx_startaddr_i = start;
        reg_tx_size_i      = size;
        reg_tx_en_i        = 1'b1;
        @(posedge clk_i); #1;
        reg_tx_en_i        = 1'b0;
        // Latched values must not follow register changes mid-frame.
        reg_tx_startaddr_i = 12'h5A5;
        reg_tx_size_i      = 16'd3;
    endtask

    task automatic run_frame(input logic [AW-1:0] start, input logic [TS-1:0] size,
                             input int mode);
        int d0 = done_cnt;
        int b0 = n_beats;
        int c  = 0;
        int nb = (size < 8) ? int'(size) : (int'(size) / 4 + int'(size) % 4);
        tr_mode = mode;
        push_frame(start, size, nb);
        request(start, size);
        while (done_cnt == d0 && c < 3000) begin
            @(posedge clk_i);
            c++;
        end
        check("done_seen", done_cnt, d0 + 1);
        @(posedge clk_i); #1;
        check("idle_after_done", busy_o, 1'b0);
        check("beats_in_frame", n_beats - b0, nb);
        repeat (3) @(posedge clk_i);
        #1;
        check("single_done", done_cnt, d0 + 1);
        tr_mode = 0;
    endtask

    // Data source: advances on its own req/valid handshake.
    initial begin
        logic hs;
        data_tx_valid_i = 1'b0;
        data_tx_i       = beat_data(0);
        forever begin
            @(negedge clk_i);
            hs = data_tx_req_o && data_tx_valid_i;
            @(posedge clk_i); #1;
            if (hs) src_idx++;
            data_tx_i       = beat_data(src_idx);
            data_tx_valid_i = ($urandom_range(3) != 0);
        end
    end

    // MAC ready pattern, applied after the main thread updates tr_mode.
    initial begin
        m_axis_tready_i = 1'b1;
        forever begin
            @(posedge clk_i); #2;
            case (tr_mode)
                1:       m_axis_tready_i = ~m_axis_tready_i;
                2:       m_axis_tready_i = 1'b0;
                default: m_axis_tready_i = 1'b1;
            endcase
        end
    end

    always @(negedge clk_i) begin
        beat_t b;
        if (rstn_i && m_axis_tvalid_o && m_axis_tready_i) begin
            n_beats++;
            if (beat_q.size() == 0) begin
                check("beat_unexpected", m_axis_tvalid_o, 1'b0);
            end else begin
                b = beat_q.pop_front();
                check("tdata", m_axis_tdata_o, b.data);
                check("tsize", m_axis_tsize_o, b.tsize);
                check("tuser", m_axis_tuser_o, b.tuser);
                check("tlast", m_axis_tlast_o, b.tlast);
            end
        end
    end

    always @(negedge clk_i) begin
        launch_t l;
        if (rstn_i && cfg_tx_en_o) begin
            if (launch_q.size() == 0) begin
                check("launch_unexpected", cfg_tx_en_o, 1'b0);
            end else begin
                l = launch_q.pop_front();
                check("launch_addr", cfg_tx_startaddr_o, l.addr);
                check("launch_size", cfg_tx_size_o, l.size);
                check("launch_dsize", cfg_tx_datasize_o, l.dsize);
                check("data_dsize", data_tx_datasize_o, l.dsize);
            end
        end
    end

    always @(negedge clk_i) begin
        if (rstn_i && done_o) done_cnt++;
        if (rstn_i && !m_axis_tready_i) begin
            check("req_stalled", data_tx_req_o, 1'b0);
            check("ready_stalled", data_tx_ready_o, 1'b0);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int d0, b0, c;
        rstn_i              = 1'b0;
        cfg_tx_en_i         = 1'b0;
        cfg_tx_pending_i    = 1'b0;
        cfg_tx_curr_addr_i  = '0;
        cfg_tx_bytes_left_i = '0;
        reg_tx_startaddr_i  = '0;
        reg_tx_size_i       = '0;
        reg_tx_continuous_i = 1'b0;
        reg_tx_en_i         = 1'b0;
        reg_tx_clr_i        = 1'b0;
        data_tx_gnt_i       = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_busy", busy_o, 1'b0);
        check("rst_done", done_o, 1'b0);
        check("rst_cfg_en", cfg_tx_en_o, 1'b0);
        check("rst_cfg_addr", cfg_tx_startaddr_o, '0);
        check("rst_cfg_size", cfg_tx_size_o, '0);
        check("rst_cfg_dsize", cfg_tx_datasize_o, 2'd0);
        check("rst_tuser", m_axis_tuser_o, 1'b0);
        check("rst_tvalid", m_axis_tvalid_o, 1'b0);
        rstn_i = 1'b1;
        @(posedge clk_i); #1;

        // Status and mode passthroughs.
        cfg_tx_en_i         = 1'b1;
        cfg_tx_pending_i    = 1'b1;
        cfg_tx_curr_addr_i  = 12'hABC;
        cfg_tx_bytes_left_i = 16'h1357;
        reg_tx_continuous_i = 1'b1;
        #1;
        check("pt_en", reg_tx_en_o, 1'b1);
        check("pt_pending", reg_tx_pending_o, 1'b1);
        check("pt_curr_addr", reg_tx_curr_addr_o, 12'hABC);
        check("pt_bytes_left", reg_tx_bytes_left_o, 16'h1357);
        check("pt_continuous", cfg_tx_continuous_o, 1'b1);
        reg_tx_continuous_i = 1'b0;
        #1;
        check("pt_continuous_lo", cfg_tx_continuous_o, 1'b0);

        run_frame(12'h000, 16'd64, 0);  // word phase only
        run_frame(12'h100, 16'd67, 0);  // word phase then 3 bytes at 0x140
        run_frame(12'h040, 16'd5,  0);  // short frame, byte phase only
        run_frame(12'h080, 16'd64, 1);  // backpressure on every other cycle

        // Abort during the word phase of a 64-byte frame.
        d0 = done_cnt;
        b0 = n_beats;
        c  = 0;
        push_frame(12'h200, 16'd64, 6);
        request(12'h200, 16'd64);
        while (n_beats < b0 + 6 && c < 3000) begin
            @(posedge clk_i);
            c++;
        end
        check("clr_beats_before", n_beats - b0, 6);
        #1;
        tr_mode      = 2;
        reg_tx_clr_i = 1'b1;
        @(negedge clk_i);
        check("clr_pulse", cfg_tx_clr_o, 1'b1);
        @(posedge clk_i); #1;
        reg_tx_clr_i = 1'b0;
        tr_mode      = 0;
        check("clr_idle", busy_o, 1'b0);
        check("clr_tuser", m_axis_tuser_o, 1'b0);
        check("clr_pulse_end", cfg_tx_clr_o, 1'b0);
        repeat (10) @(posedge clk_i);
        #1;
        check("clr_no_done", done_cnt, d0);
        check("clr_no_more_beats", n_beats - b0, 6);
        run_frame(12'h300, 16'd4, 0);   // clean frame after the abort

        // Zero-length request is ignored.
        d0 = done_cnt;
        reg_tx_size_i = '0;
        reg_tx_en_i   = 1'b1;
        repeat (4) @(posedge clk_i);
        #1;
        reg_tx_en_i = 1'b0;
        check("zero_busy", busy_o, 1'b0);
        check("zero_no_done", done_cnt, d0);

        // Clear and request in the same idle cycle: clear wins.
        push_frame(12'h000, 16'd0, 0);
        reg_tx_size_i = 16'd16;
        reg_tx_en_i   = 1'b1;
        reg_tx_clr_i  = 1'b1;
        @(posedge clk_i); #1;
        reg_tx_en_i  = 1'b0;
        reg_tx_clr_i = 1'b0;
        check("clr_wins_busy", busy_o, 1'b0);

        run_frame(12'hFFC, 16'd14, 0);  // byte phase address wraps to 0x008
        run_frame(12'hFFC, 16'd12, 0);
        run_frame(12'h010, 16'd9,  1);

        check("launch_q_empty", launch_q.size(), 0);
        check("beat_q_empty", beat_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
